// File: rtl/deck_shuffler_param_pkg.sv
// Shared types and constants for the parameterised deck shuffler.
//   state_t           : shuffler FSM states
//   MODE_RANDOM/REVERSE: mode encodings sampled on the start edge
//   DEFAULT_LFSR_TAPS : default Galois feedback mask
package shuffler_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PICK,
        S_RD_I,
        S_RD_J,
        S_CAP_J,
        S_WR_I,
        S_WR_J,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic MODE_RANDOM  = 1'b0;
    localparam logic MODE_REVERSE = 1'b1;

    localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/deck_shuffler_param_if.sv
// Bundle between the shuffler, the game FSM and the single-port card RAM.
//   start/mode/seed   : run control from the game FSM
//   busy/finish       : status back to the game FSM
//   nextA/newData/wren: RAM address, write data, write enable
//   memData           : RAM read data, valid one cycle after its address
// slave = shuffler side, master = FSM + RAM side.
interface shuffler_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 6,
    parameter int LFSR_W = 16
);
    logic              start;
    logic              mode;
    logic [LFSR_W-1:0] seed;
    logic [DATA_W-1:0] memData;
    logic [ADDR_W-1:0] nextA;
    logic [DATA_W-1:0] newData;
    logic              wren;
    logic              busy;
    logic              finish;

    modport slave (
        input  start, mode, seed, memData,
        output nextA, newData, wren, busy, finish
    );

    modport master (
        output start, mode, seed, memData,
        input  nextA, newData, wren, busy, finish
    );
endinterface

// File: rtl/deck_shuffler_param_lfsr.sv
// Galois LFSR used as the shuffle's random source.
//   clock, reset_n : clock, async active-low reset (value resets to 1)
//   load, seed     : load seed (a zero seed is replaced by 1); load wins over step
//   step           : advance one position
//   value          : current register contents, never zero
module lfsr_galois #(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = W'(16'hB400)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         step,
    output logic [W-1:0] value
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= W'(1);
        end else if (load) begin
            value <= (seed == '0) ? W'(1) : seed;
        end else if (step) begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/deck_shuffler_param.sv
// In-place permutation of a DECK-entry region of the card RAM.
// Mode 0: Fisher-Yates with LFSR rejection sampling. Mode 1: full reversal.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : start/mode/seed in, busy/finish out, RAM port
// All outputs are decoded from registered state; none depend on memData.
module deck_shuffler_param
    import shuffler_pkg::*;
#(
    parameter int                DATA_W    = 4,
    parameter int                ADDR_W    = 6,
    parameter int                DECK      = 52,
    parameter int                BASE      = 0,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEFAULT_LFSR_TAPS)
) (
    input logic       clock,
    input logic       reset_n,
    shuffler_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DECK - 1);
    localparam logic [ADDR_W-1:0] HALF   = ADDR_W'(DECK / 2);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    // Smallest 2^k-1 covering v: propagate the top set bit downwards.
    function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] m;
        m = v;
        for (int k = 0; k < ADDR_W; k++) m = m | (m >> 1);
        return m;
    endfunction

    state_t            state, state_n;
    logic              mode_q, mode_n;
    logic [ADDR_W-1:0] i, i_n, j, j_n;
    logic [DATA_W-1:0] di, di_n, dj, dj_n;
    logic              lfsr_load, lfsr_step;
    logic [LFSR_W-1:0] lfsr_val;
    logic [ADDR_W-1:0] cand;
    logic              unused_lfsr_bits;

    lfsr_galois #(.W(LFSR_W), .TAPS(LFSR_TAPS)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .seed    (bus.seed),
        .step    (lfsr_step),
        .value   (lfsr_val)
    );

    // Only the low ADDR_W bits feed the candidate; the rest just circulate.
    assign unused_lfsr_bits = ^lfsr_val;
    assign cand             = lfsr_val[ADDR_W-1:0] & smear(i);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            mode_q <= MODE_RANDOM;
            i      <= '0;
            j      <= '0;
            di     <= '0;
            dj     <= '0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            i      <= i_n;
            j      <= j_n;
            di     <= di_n;
            dj     <= dj_n;
        end
    end

    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        i_n       = i;
        j_n       = j;
        di_n      = di;
        dj_n      = dj;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    mode_n    = bus.mode;
                    lfsr_load = 1'b1;
                    i_n       = (bus.mode == MODE_REVERSE) ? '0 : LAST;
                    state_n   = S_PICK;
                end
            end
            S_PICK: begin
                if (!bus.start) begin
                    state_n = S_IDLE;
                end else if (mode_q == MODE_REVERSE) begin
                    j_n     = LAST - i;
                    state_n = (j_n == i) ? S_NEXT : S_RD_I;
                end else begin
                    // Rejection sampling: out-of-range candidates retry next cycle.
                    lfsr_step = 1'b1;
                    if (cand <= i) begin
                        j_n     = cand;
                        state_n = (cand == i) ? S_NEXT : S_RD_I;
                    end
                end
            end
            S_RD_I:  state_n = S_RD_J;
            S_RD_J: begin
                di_n    = bus.memData;
                state_n = S_CAP_J;
            end
            S_CAP_J: begin
                dj_n    = bus.memData;
                state_n = S_WR_I;
            end
            S_WR_I:  state_n = S_WR_J;
            S_WR_J:  state_n = S_NEXT;
            S_NEXT: begin
                if (!bus.start) begin
                    state_n = S_IDLE;
                end else if (mode_q == MODE_RANDOM) begin
                    i_n     = i - ADDR_W'(1);
                    state_n = (i == ADDR_W'(1)) ? S_DONE : S_PICK;
                end else begin
                    i_n     = i + ADDR_W'(1);
                    state_n = (i_n == HALF) ? S_DONE : S_PICK;
                end
            end
            S_DONE: begin
                if (!bus.start) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.nextA   = '0;
        bus.newData = '0;
        case (state)
            S_RD_I: bus.nextA = BASE_A + i;
            S_RD_J: bus.nextA = BASE_A + j;
            S_WR_I: begin
                bus.nextA   = BASE_A + i;
                bus.newData = dj;
            end
            S_WR_J: begin
                bus.nextA   = BASE_A + j;
                bus.newData = di;
            end
            default: ;
        endcase
    end

    assign bus.wren   = (state == S_WR_I) || (state == S_WR_J);
    assign bus.busy   = (state != S_IDLE) && (state != S_DONE);
    assign bus.finish = (state == S_DONE);

endmodule

// File: tb/tb_deck_shuffler_param.sv
// Bench for deck_shuffler_param: a 52-card wide-data build (A) and a
// 2-card build at BASE 10 (B), each with a synchronous RAM model.
// A reference shuffle computed from the algorithm's rules supplies the
// expected write sequence and final RAM contents.
module tb_deck_shuffler_param;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    shuffler_if #(.DATA_W(6), .ADDR_W(6), .LFSR_W(16)) ifa ();
    shuffler_if #(.DATA_W(4), .ADDR_W(6), .LFSR_W(16)) ifb ();

    deck_shuffler_param #(.DATA_W(6), .ADDR_W(6), .DECK(52), .BASE(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(ifa));
    deck_shuffler_param #(.DATA_W(4), .ADDR_W(6), .DECK(2), .BASE(10)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(ifb));

    logic [5:0] mem_a [64];
    logic [3:0] mem_b [64];
    logic       ld_en = 1'b0;
    int         ld_addr = 0, ld_data = 0;
    int         sel = 0;

    always @(posedge clock) begin
        if (ld_en && sel == 0) mem_a[ld_addr] <= 6'(ld_data);
        else if (ifa.wren)     mem_a[ifa.nextA] <= ifa.newData;
        ifa.memData <= mem_a[ifa.nextA];
    end

    always @(posedge clock) begin
        if (ld_en && sel == 1) mem_b[ld_addr] <= 4'(ld_data);
        else if (ifb.wren)     mem_b[ifb.nextA] <= ifb.newData;
        ifb.memData <= mem_b[ifb.nextA];
    end

    int pass_cnt = 0, tot_cnt = 0;
    int m0 [64];
    int ex [64];
    int wa [256];
    int wd [256];
    int nw = 0, rp = 0, pulses = 0;
    bit mon_en = 0;
    logic wr, fin, bz;
    int ad, dt;
    int r1 [64];
    int r2 [64];

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int lstep(input int v);
        return (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
    endfunction

    function automatic int smear(input int v);
        int m = 0;
        while (m < v) m = m * 2 + 1;
        return m;
    endfunction

    // Reference shuffle on a copy of m0; records the writes a correct
    // shuffler must issue, in order.
    task automatic model_build(input int deck, input int base, input int md, input int sd);
        int t [64];
        int lf, c;
        for (int k = 0; k < 64; k++) t[k] = m0[k];
        nw = 0;
        lf = sd & 'hFFFF;
        if (lf == 0) lf = 1;
        if (md == 1) begin
            for (int x = 0; x < deck / 2; x++) begin
                int y = deck - 1 - x;
                wa[nw] = base + x; wd[nw] = t[base + y];
                wa[nw+1] = base + y; wd[nw+1] = t[base + x];
                nw += 2;
                c = t[base + x]; t[base + x] = t[base + y]; t[base + y] = c;
            end
        end else begin
            for (int x = deck - 1; x >= 1; x--) begin
                do begin
                    c = (lf & 63) & smear(x);
                    lf = lstep(lf);
                end while (c > x);
                if (c != x) begin
                    int s;
                    wa[nw] = base + x; wd[nw] = t[base + c];
                    wa[nw+1] = base + c; wd[nw+1] = t[base + x];
                    nw += 2;
                    s = t[base + x]; t[base + x] = t[base + c]; t[base + c] = s;
                end
            end
        end
    endtask

    task automatic apply_writes(input int n);
        for (int k = 0; k < 64; k++) ex[k] = m0[k];
        for (int w = 0; w < n; w++) ex[wa[w]] = wd[w];
    endtask

    function automatic int mism();
        int n = 0;
        for (int k = 0; k < 64; k++) begin
            if (sel == 0 && int'(mem_a[k]) != ex[k]) n++;
            if (sel == 1 && int'(mem_b[k]) != ex[k]) n++;
        end
        return n;
    endfunction

    // Number of values 0..51 not appearing exactly once in mem_a[0..51].
    function automatic int perm_err();
        int cnt [64];
        int n = 0;
        for (int k = 0; k < 64; k++) cnt[k] = 0;
        for (int k = 0; k < 52; k++) cnt[mem_a[k]]++;
        for (int k = 0; k < 52; k++) if (cnt[k] != 1) n++;
        return n;
    endfunction

    // pat 0: k mod 16, 1: identity, 2: random
    task automatic load_ram(input int pat);
        for (int k = 0; k < 64; k++) begin
            int v;
            if (pat == 0)      v = k % 16;
            else if (pat == 1) v = k;
            else               v = int'($urandom_range(0, 63));
            if (sel == 1) v = v % 16;
            m0[k] = v;
            ld_en = 1'b1; ld_addr = k; ld_data = v;
            @(negedge clock);
        end
        ld_en = 1'b0;
    endtask

    task automatic drive(input logic st, input int md, input int sd);
        if (sel == 0) begin
            ifa.start = st; ifa.mode = md[0]; ifa.seed = 16'(sd);
        end else begin
            ifb.start = st; ifb.mode = md[0]; ifb.seed = 16'(sd);
        end
    endtask

    // One cycle, sampled at the falling edge; every write is checked in order.
    task automatic cycle();
        @(negedge clock);
        wr  = sel ? ifb.wren   : ifa.wren;
        fin = sel ? ifb.finish : ifa.finish;
        bz  = sel ? ifb.busy   : ifa.busy;
        ad  = sel ? int'(ifb.nextA)   : int'(ifa.nextA);
        dt  = sel ? int'(ifb.newData) : int'(ifa.newData);
        if (wr) pulses++;
        if (mon_en && wr) begin
            if (rp < nw) begin
                chk("wr_addr", ad, wa[rp]);
                chk("wr_data", dt, wd[rp]);
            end else begin
                chk("extra_write", 1, 0);
            end
            rp++;
        end
    endtask

    // Full run; edges = rising edges after the start-sampling edge until finish.
    task automatic run(input int md, input int sd, input int budget, output int edges);
        bit ok = 0;
        rp = 0; pulses = 0; mon_en = 1;
        drive(1'b1, md, sd);
        cycle();
        chk("busy_after_start", int'(bz), 1);
        edges = 0;
        while (edges < budget && !ok) begin
            cycle();
            edges++;
            if (fin) ok = 1;
        end
        chk("finish_seen", int'(ok), 1);
        chk("write_count", rp, nw);
        drive(1'b0, md, sd);
        cycle();
        chk("finish_clear", int'(fin), 0);
        mon_en = 0;
    endtask

    initial begin
        int e;
        int d;
        bit hit;
        drive(1'b0, 0, 0);
        sel = 1; drive(1'b0, 0, 0); sel = 0;
        repeat (2) @(negedge clock);
        chk("rst_nextA", int'(ifa.nextA), 0);
        chk("rst_newData", int'(ifa.newData), 0);
        chk("rst_wren", int'(ifa.wren), 0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_finish", int'(ifa.finish), 0);
        reset_n = 1'b1;
        @(negedge clock);

        chk("model_lstep", lstep('hACE1), 'hE270);
        chk("model_smear5", smear(5), 7);
        chk("model_smear32", smear(32), 63);

        // Reversal, DECK 52
        sel = 0;
        load_ram(0);
        model_build(52, 0, 1, 0);
        run(1, 0, 400, e);
        chk("rev_edges", e, 182);
        chk("rev_pulses", pulses, 52);
        apply_writes(nw);
        chk("rev_ram", mism(), 0);
        chk("rev_mem0", int'(mem_a[0]), 3);
        chk("rev_mem51", int'(mem_a[51]), 0);

        // Fisher-Yates, seed ACE1
        load_ram(1);
        model_build(52, 0, 0, 'hACE1);
        run(0, 'hACE1, 3000, e);
        apply_writes(nw);
        chk("fy_ram", mism(), 0);
        chk("fy_perm", perm_err(), 0);
        for (int k = 0; k < 64; k++) r1[k] = int'(mem_a[k]);

        load_ram(1);
        model_build(52, 0, 0, 'hACE1);
        run(0, 'hACE1, 3000, e);
        d = 0;
        for (int k = 0; k < 64; k++) if (int'(mem_a[k]) != r1[k]) d++;
        chk("fy_repeat_same", d, 0);

        load_ram(1);
        model_build(52, 0, 0, 1);
        run(0, 1, 3000, e);
        apply_writes(nw);
        chk("fy_seed1_ram", mism(), 0);
        d = 0;
        for (int k = 0; k < 64; k++) begin
            r2[k] = int'(mem_a[k]);
            if (r2[k] != r1[k]) d++;
        end
        chk("fy_seed1_differs", int'(d > 0), 1);

        load_ram(1);
        model_build(52, 0, 0, 0);
        run(0, 0, 3000, e);
        d = 0;
        for (int k = 0; k < 64; k++) if (int'(mem_a[k]) != r2[k]) d++;
        chk("fy_seed0_eq_seed1", d, 0);

        // Abort during the 10th swap's second write
        load_ram(1);
        model_build(52, 0, 0, 'hACE1);
        rp = 0; pulses = 0; mon_en = 1;
        drive(1'b1, 0, 'hACE1);
        e = 0;
        while (pulses < 20 && e < 2000) begin cycle(); e++; end
        chk("abort_reached", pulses, 20);
        drive(1'b0, 0, 'hACE1);
        cycle();
        cycle();
        chk("abort_idle", int'(bz), 0);
        hit = 0;
        repeat (20) begin cycle(); if (fin) hit = 1; end
        chk("abort_no_finish", int'(hit), 0);
        chk("abort_writes", rp, 20);
        mon_en = 0;
        apply_writes(20);
        chk("abort_ram", mism(), 0);
        chk("abort_perm", perm_err(), 0);

        // Asynchronous reset while in the first write
        load_ram(1);
        model_build(52, 0, 0, 'hACE1);
        rp = 0; pulses = 0; mon_en = 1;
        drive(1'b1, 0, 'hACE1);
        e = 0;
        while (pulses == 0 && e < 2000) begin cycle(); e++; end
        chk("rst_mid_reached", pulses, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_wren", int'(ifa.wren), 0);
        chk("rst_mid_busy", int'(ifa.busy), 0);
        chk("rst_mid_finish", int'(ifa.finish), 0);
        mon_en = 0;
        drive(1'b0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) cycle();
        chk("rst_mid_idle_busy", int'(bz), 0);
        chk("rst_mid_idle_fin", int'(fin), 0);
        apply_writes(0);
        chk("rst_mid_ram", mism(), 0);

        // Two-card build at BASE 10
        sel = 1;
        load_ram(0);
        model_build(2, 10, 1, 0);
        run(1, 0, 50, e);
        chk("d2_rev_edges", e, 7);
        chk("d2_rev_pulses", pulses, 2);
        chk("d2_mem10", int'(mem_b[10]), 11);
        chk("d2_mem11", int'(mem_b[11]), 10);
        apply_writes(nw);
        chk("d2_rev_ram", mism(), 0);

        load_ram(0);
        model_build(2, 10, 0, 1);
        run(0, 1, 50, e);
        chk("d2_fy_pulses", pulses, 0);
        chk("d2_fy_edges", e, 2);
        apply_writes(0);
        chk("d2_fy_ram", mism(), 0);

        // Randomised runs on the 52-card build
        sel = 0;
        for (int t = 0; t < 4; t++) begin
            int md, sd;
            md = int'($urandom_range(0, 1));
            sd = int'($urandom & 32'hFFFF);
            load_ram(2);
            model_build(52, 0, md, sd);
            run(md, sd, 3000, e);
            apply_writes(nw);
            chk("rand_ram", mism(), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
